gpio_uart_tx: RTL and testbench

GPIO_UART_TX -- requirements
Module: gpio_uart_tx

---
 rtl/gpio_uart_tx_pkg.sv | 31 +++
 rtl/gpio_uart_tx_fifo.sv | 81 ++++++++
 rtl/gpio_uart_tx.sv | 167 ++++++++++++++++
 tb/tb_gpio_uart_tx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_uart_tx_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : gpio_uart_tx_pkg
// Purpose  : Shared FSM state type, status bit map and defaults for gpio_uart_tx.
// Revision : 1.0 - initial release
// ============================================================================
package gpio_uart_tx_pkg;

    localparam int c_default_clks_per_bit = 16;
    localparam int c_bytes_per_word       = 4;
    localparam int c_bits_per_byte        = 8;

    // Bit positions inside the CPU-visible status word.
    localparam int c_stat_busy      = 0;
    localparam int c_stat_full      = 1;
    localparam int c_stat_empty     = 2;
    localparam int c_stat_count_lsb = 3;
    localparam int c_stat_count_msb = 5;
    localparam int c_stat_drop_lsb  = 8;
    localparam int c_stat_drop_msb  = 15;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

endpackage : gpio_uart_tx_pkg
`default_nettype wire

// File: rtl/gpio_uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : word_fifo
// Purpose  : Synchronous word FIFO; a push into a full FIFO is accepted only
//            when a pop happens on the same edge, otherwise it is reported.
// Revision : 1.0 - initial release
// ============================================================================
module word_fifo
    import gpio_uart_tx_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count,
    output logic             o_drop
);

    localparam logic [AW-1:0] c_ptr_last = AW'(DEPTH - 1);
    localparam logic [CW-1:0] c_count_max = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_full;
    logic w_empty;
    logic w_wr_en;
    logic w_rd_en;

    assign w_full  = (r_count == c_count_max);
    assign w_empty = (r_count == '0);
    assign w_rd_en = i_pop && !w_empty;
    // The slot freed by a same-edge pop makes room for the incoming word.
    assign w_wr_en = i_push && (!w_full || w_rd_en);

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;
    assign o_drop  = i_push && w_full && !w_rd_en;

endmodule : word_fifo
`default_nettype wire

// File: rtl/gpio_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : gpio_uart_tx
// Purpose  : Captures changes of a CPU GPIO word, buffers them and sends each
//            word as four 8N1 UART bytes, low byte first.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_uart_tx
    import gpio_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_default_clks_per_bit,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] gpio_word,
    output logic        tx,
    output logic [31:0] status
);

    localparam int CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int FCW     = $clog2(FIFO_DEPTH + 1);
    localparam int STAT_CW = c_stat_count_msb - c_stat_count_lsb + 1;

    localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       c_data_last = 3'(c_bits_per_byte - 1);
    localparam logic [1:0]       c_byte_last = 2'(c_bytes_per_word - 1);

    tx_state_t        r_state;
    logic [31:0]      r_prev_word;
    logic [31:0]      r_shift;
    logic [1:0]       r_byte_idx;
    logic [2:0]       r_bit_idx;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_tx;
    logic [7:0]       r_drop_cnt;

    logic             w_change;
    logic             w_pop;
    logic             w_bit_done;
    logic [31:0]      w_fifo_data;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [FCW-1:0]   w_fifo_count;
    logic             w_fifo_drop;

    assign w_change   = (gpio_word != r_prev_word);
    assign w_pop      = (r_state == S_IDLE) && !w_fifo_empty;
    assign w_bit_done = (r_bit_cnt == c_bit_last);

    word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_change),
        .i_pop   (w_pop),
        .i_data  (gpio_word),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count),
        .o_drop  (w_fifo_drop)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_word <= '0;
        end else if (w_change) begin
            r_prev_word <= gpio_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_fifo_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    // tx is registered and loaded one edge ahead, so each line level lines up
    // exactly with the state that owns it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_byte_idx <= '0;
            r_bit_idx  <= '0;
            r_bit_cnt  <= '0;
            r_tx       <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift    <= w_fifo_data;
                        r_byte_idx <= '0;
                        r_bit_idx  <= '0;
                        r_bit_cnt  <= '0;
                        r_tx       <= 1'b0;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_done) begin
                        r_bit_cnt <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bit_done) begin
                        r_bit_cnt <= '0;
                        r_shift   <= {1'b0, r_shift[31:1]};
                        if (r_bit_idx == c_data_last) begin
                            r_bit_idx <= '0;
                            r_tx      <= 1'b1;
                            r_state   <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_bit_done) begin
                        r_bit_cnt <= '0;
                        if (r_byte_idx == c_byte_last) begin
                            r_tx    <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_byte_idx <= r_byte_idx + 1'b1;
                            r_tx       <= 1'b0;
                            r_state    <= S_START;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        status = '0;
        status[c_stat_busy]  = (r_state != S_IDLE);
        status[c_stat_full]  = w_fifo_full;
        status[c_stat_empty] = w_fifo_empty;
        status[c_stat_count_msb:c_stat_count_lsb] = STAT_CW'(w_fifo_count);
        status[c_stat_drop_msb:c_stat_drop_lsb]   = r_drop_cnt;
    end

    assign tx = r_tx;

endmodule : gpio_uart_tx
`default_nettype wire

// File: tb/tb_gpio_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_gpio_uart_tx
// Purpose  : Self-checking bench for gpio_uart_tx against a frame-timing model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 40 * CPB;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] gpio_word;
    logic        tx;
    logic [31:0] status;
    logic        cmp_en = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gpio_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .gpio_word (gpio_word),
        .tx        (tx),
        .status    (status)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of pending words plus the time elapsed in the current frame.
    logic [31:0] m_prev;
    logic [31:0] m_q[$];
    logic [31:0] m_word;
    int          m_drop;
    int          m_elapsed;
    bit          m_active;
    bit          m_pop;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_prev    = '0;
            m_q.delete();
            m_word    = '0;
            m_drop    = 0;
            m_elapsed = 0;
            m_active  = 0;
        end else begin
            m_pop = !m_active && (m_q.size() != 0);
            if (m_pop) begin
                m_word    = m_q.pop_front();
                m_active  = 1;
                m_elapsed = 0;
            end else if (m_active) begin
                m_elapsed++;
                if (m_elapsed == FRAME) m_active = 0;
            end
            if (gpio_word != m_prev) begin
                m_prev = gpio_word;
                if (m_q.size() < DEPTH) m_q.push_back(gpio_word);
                else if (m_drop < 255) m_drop++;
            end
        end
    end

    function automatic logic exp_tx();
        int bitn;
        int pos;
        if (!m_active) return 1'b1;
        bitn = m_elapsed / CPB;
        pos  = bitn % 10;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return m_word[(bitn / 10) * 8 + pos - 1];
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        logic [7:0]  d;
        d = 8'(m_drop);
        s = '0;
        s[0]    = m_active;
        s[1]    = (m_q.size() == DEPTH);
        s[2]    = (m_q.size() == 0);
        s[5:3]  = 3'(m_q.size());
        s[15:8] = d;
        return s;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_tx", {31'b0, tx}, {31'b0, exp_tx()});
            check("model_status", status, exp_status());
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] words [6] = '{32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF,
                               32'hFFFF_0000, 32'h0000_FFFF, 32'h5A5A_A5A5};

    initial begin
        int          n;
        int          busy_cnt;
        int          rises;
        int          lows;
        logic        prev_busy;
        logic [31:0] rx;

        gpio_word = '0;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        check("reset_status", status, 32'h0000_0004);
        check("reset_tx", {31'b0, tx}, 32'h1);
        rst = 1'b0;
        cyc();

        // Single word: latency, byte decode, busy duration.
        gpio_word = 32'hA5C3_0F81;
        n = 0;
        do begin cyc(); n++; end while (tx !== 1'b0 && n < 10);
        check("t1_latency", 32'(n), 32'd2);
        busy_cnt = 0;
        rx = '0;
        for (int e = 0; e < FRAME; e++) begin
            if (status[0]) busy_cnt++;
            if (e % CPB == CPB / 2) begin
                if ((e / CPB) % 10 >= 1 && (e / CPB) % 10 <= 8)
                    rx[((e / CPB) / 10) * 8 + (e / CPB) % 10 - 1] = tx;
            end
            cyc();
        end
        check("t1_busy_cycles", 32'(busy_cnt), 32'd160);
        check("t1_byte0", {24'b0, rx[7:0]},   32'h81);
        check("t1_byte1", {24'b0, rx[15:8]},  32'h0F);
        check("t1_byte2", {24'b0, rx[23:16]}, 32'hC3);
        check("t1_byte3", {24'b0, rx[31:24]}, 32'hA5);
        check("t1_final_status", status, 32'h0000_0004);

        // Held word transmits once.
        gpio_word = 32'h1234_5678;
        rises = 0;
        prev_busy = 1'b0;
        repeat (500) begin
            cyc();
            if (status[0] && !prev_busy) rises++;
            prev_busy = status[0];
        end
        check("t2_single_frame", 32'(rises), 32'd1);
        check("t2_final_status", status, 32'h0000_0004);

        // Six back-to-back words: one pops, four buffer, one drops.
        for (int i = 0; i < 6; i++) begin
            gpio_word = words[i];
            cyc();
            if (i == 4) check("t3_full_at_5th", status, 32'h0000_0023);
            if (i == 5) check("t3_full_drop", status, 32'h0000_0123);
        end
        n = 0;
        while (status[0] && n < 200) begin cyc(); n++; end
        check("t3_wait_idle", {31'b0, n < 200}, 32'h1);
        check("t3_idle_full", status, 32'h0000_0122);

        // New word lands on the pop edge of a full FIFO.
        gpio_word = 32'h7777_1234;
        cyc();
        check("t4_pop_push", status, 32'h0000_0123);
        n = 0;
        while (status !== 32'h0000_0104 && n < 1200) begin cyc(); n++; end
        check("t3_drained", status, 32'h0000_0104);

        // Reset in the middle of byte 2 data.
        gpio_word = 32'hC0FF_EE42;
        n = 0;
        while (!status[0] && n < 10) begin cyc(); n++; end
        check("t5_started", {31'b0, status[0]}, 32'h1);
        repeat (24 * CPB) cyc();
        #2;
        rst = 1'b1;
        gpio_word = '0;
        #1;
        check("t5_tx_async", {31'b0, tx}, 32'h1);
        check("t5_status", status, 32'h0000_0004);
        cyc();
        rst = 1'b0;
        lows = 0;
        repeat (200) begin
            cyc();
            if (tx !== 1'b1) lows++;
        end
        check("t5_no_restart", 32'(lows), 32'd0);

        // Non-zero word present as reset releases is pushed.
        rst = 1'b1;
        gpio_word = 32'h3C3C_0001;
        cyc();
        rst = 1'b0;
        n = 0;
        do begin cyc(); n++; end while (tx !== 1'b0 && n < 10);
        check("t6_post_reset_latency", 32'(n), 32'd2);
        n = 0;
        while (status !== 32'h0000_0004 && n < 400) begin cyc(); n++; end
        check("t6_done", status, 32'h0000_0004);

        // Flood to saturate the drop counter.
        for (int i = 0; i < 320; i++) begin
            gpio_word = 32'h8000_0000 | 32'(i);
            cyc();
        end
        check("t7_drop_sat", {24'b0, status[15:8]}, 32'h0000_00FF);
        n = 0;
        while (status !== 32'h0000_FF04 && n < 1500) begin cyc(); n++; end
        check("t7_drained", status, 32'h0000_FF04);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_gpio_uart_tx
`default_nettype wire
